manual_input_conditioner: RTL and testbench
===========================================

Name: manual_input_conditioner

Overview:
- Upstream stage of traffic_light_controller; generates its manual_override and manual_state inputs.
- Takes two raw, asynchronous, bouncing push-buttons (mode toggle, next-colour).
- Synchronises and debounces both buttons, then edge-detects them into one-cycle press pulses.
- A two-state mode FSM uses the pulses to drive a stable override flag and colour code, with an inactivity timeout that returns the controller to automatic mode.

Parameters:
- CLK_HZ, 100000000, clock frequency; sets the 1 s tick prescaler.
- DEBOUNCE_CYCLES, 1000000, cycles a synced input must hold a new level before it is accepted (10 ms at 100 MHz).
- TIMEOUT_S, 30, seconds without an accepted press before MANUAL exits to AUTO; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_override  input  1  raw mode-toggle button, active-high, asynchronous.
- btn_next  input  1  raw next-colour button, active-high, asynchronous.
- manual_override  output  1  1 = controller follows manual_state.
- manual_state  output  2  00 red, 10 green, 01 yellow; 11 never driven.
- override_pulse  output  1  one-cycle strobe per accepted btn_override press.
- next_pulse  output  1  one-cycle strobe per accepted btn_next press.

Behaviour:
- Reset (reset=0, async):
  - Outputs: manual_override=0, manual_state=00, both pulses 0.
  - Internal: synchronisers 0, debounced levels 0, debounce counters 0, prescaler 0, idle-seconds counter 0, FSM=AUTO.
  - Reset asserted mid-debounce or mid-timeout discards all progress.
- Synchroniser: 2-flop per button; all further logic uses only the synced value.
- Debounce, per button:
  - Counter clears whenever synced value equals the debounced level.
  - While they differ, counter increments.
  - When counter reaches DEBOUNCE_CYCLES-1 and they still differ, debounced level takes the synced value and the counter clears.
  - Any bounce back before that point restarts the count.
- Edge detect: press pulse = debounced level rising 0->1; exactly one cycle, registered.
  - Release (1->0) is debounced the same way but produces no pulse.
  - Holding a button produces exactly one pulse.
- Latency: raw edge to pulse = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, given a clean input.
- Prescaler: free-running 0..CLK_HZ-1; sec_tick is high for one cycle at wrap.
- FSM AUTO:
  - manual_override=0; manual_state held at 00.
  - override_pulse -> MANUAL, manual_state=00, idle counter cleared.
  - next_pulse ignored.
- FSM MANUAL:
  - manual_override=1.
  - next_pulse advances manual_state 00->10->01->00 (red->green->yellow->red) and clears the idle counter.
  - override_pulse -> AUTO, manual_state=00.
  - On sec_tick the idle counter increments.
  - When TIMEOUT_S!=0 and the idle counter reaches TIMEOUT_S -> AUTO, manual_state=00.
- Simultaneous events:
  - override_pulse and next_pulse in the same cycle: override wins and next is dropped (AUTO: enter MANUAL at 00; MANUAL: exit to AUTO).
  - A press pulse in the same cycle as the timeout condition: the press takes priority and the timeout is not taken. An override press still exits; a next press advances the colour and clears the idle counter.
- Outputs are registered and change only on clk edges, except on asynchronous reset.
- Counter widths are sized with $clog2 of the respective parameter and never wrap unintentionally.

Test Plan:
Bench parameters: CLK_HZ=10, DEBOUNCE_CYCLES=4, TIMEOUT_S=3.
1. Reset, then clean btn_override high for 20 cycles -> exactly one override_pulse at cycle 2+4+1=7 after the edge; manual_override=1, manual_state=00.
2. In MANUAL, three clean btn_next presses -> manual_state 10, 01, 00 in order, one next_pulse each; manual_override stays 1.
3. btn_override toggling every 2 cycles for 30 cycles, then released -> no override_pulse and FSM unchanged; repeat with a 3-cycle high glitch -> no pulse.
4. Enter MANUAL with no further presses -> manual_override falls 3 s (30 cycles +/- one prescaler period) later; manual_state=00. A next press at 2 s -> timeout restarts from that press.
5. Both buttons pressed on the same edge in AUTO -> manual_override=1, manual_state=00 (not 10). Same in MANUAL -> manual_override=0.
6. reset=0 asynchronously while in MANUAL with manual_state=10 and a debounce count in progress -> outputs go to 0/00 immediately without waiting for clk; after release, a held button needs a full DEBOUNCE_CYCLES before it pulses.

Source files
------------

// File: rtl/manual_input_conditioner.sv
// rtl/manual_input_conditioner.sv - debounced manual override / colour selector feeding the traffic light controller
// Two raw buttons are synchronised, debounced and edge-detected; a two-state FSM turns the press pulses into override controls.

module manual_input_conditioner #(
    parameter int CLK_HZ          = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_S       = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_override,
    input  logic       btn_next,
    output logic       manual_override,
    output logic [1:0] manual_state,
    output logic       override_pulse,
    output logic       next_pulse
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int IW = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PS_LAST    = PW'(CLK_HZ - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_S);

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] YELLOW = 2'b01;

    typedef enum logic {
        AUTO   = 1'b0,
        MANUAL = 1'b1
    } mode_t;

    // Bit 0 carries btn_override, bit 1 carries btn_next through every stage.
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    level;
    logic [1:0]    level_d;
    logic [DW-1:0] db_cnt [2];

    logic [PW-1:0] presc;
    logic [IW-1:0] idle_secs;
    logic          sec_tick;
    mode_t         mode;

    assign sec_tick = (presc == PS_LAST);

    function automatic logic [1:0] advance(input logic [1:0] colour);
        case (colour)
            RED:     advance = GREEN;
            GREEN:   advance = YELLOW;
            default: advance = RED;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a         <= '0;
            sync_b         <= '0;
            level          <= '0;
            level_d        <= '0;
            db_cnt[0]      <= '0;
            db_cnt[1]      <= '0;
            override_pulse <= 1'b0;
            next_pulse     <= 1'b0;
        end else begin
            sync_a  <= {btn_next, btn_override};
            sync_b  <= sync_a;
            level_d <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            // Only the press (rising) edge of the debounced level is reported.
            override_pulse <= level[0] & ~level_d[0];
            next_pulse     <= level[1] & ~level_d[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc           <= '0;
            idle_secs       <= '0;
            mode            <= AUTO;
            manual_override <= 1'b0;
            manual_state    <= RED;
        end else begin
            presc <= sec_tick ? '0 : presc + 1'b1;
            case (mode)
                AUTO: begin
                    manual_override <= 1'b0;
                    manual_state    <= RED;
                    if (override_pulse) begin
                        mode            <= MANUAL;
                        manual_override <= 1'b1;
                        idle_secs       <= '0;
                    end
                end
                MANUAL: begin
                    // Presses outrank the timeout; override outranks next.
                    if (override_pulse) begin
                        mode            <= AUTO;
                        manual_override <= 1'b0;
                        manual_state    <= RED;
                    end else if (next_pulse) begin
                        manual_state <= advance(manual_state);
                        idle_secs    <= '0;
                    end else if (TIMEOUT_S != 0 && idle_secs == IDLE_LIMIT) begin
                        mode            <= AUTO;
                        manual_override <= 1'b0;
                        manual_state    <= RED;
                    end else if (TIMEOUT_S != 0 && sec_tick) begin
                        idle_secs <= idle_secs + 1'b1;
                    end
                end
                default: begin
                    mode            <= AUTO;
                    manual_override <= 1'b0;
                    manual_state    <= RED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manual_input_conditioner.sv
// tb/tb_manual_input_conditioner.sv - scoreboard bench for manual_input_conditioner
// A planned press schedule feeds an event-level model; a monitor compares pulses and output changes against it.

module tb_manual_input_conditioner;

    localparam int CLK_HZ = 10;
    localparam int DB     = 4;
    localparam int TO     = 3;

    localparam int K_OVR      = 0;
    localparam int K_NEXT     = 1;
    localparam int K_BOTH     = 2;
    localparam int K_TOG_OVR  = 3;
    localparam int K_TOG_NEXT = 4;
    localparam int K_GL_OVR   = 5;
    localparam int K_GL_NEXT  = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_override = 1'b0;
    logic       btn_next = 1'b0;
    logic       manual_override;
    logic [1:0] manual_state;
    logic       override_pulse;
    logic       next_pulse;

    manual_input_conditioner #(
        .CLK_HZ(CLK_HZ),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_S(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_override(btn_override),
        .btn_next(btn_next),
        .manual_override(manual_override),
        .manual_state(manual_state),
        .override_pulse(override_pulse),
        .next_pulse(next_pulse)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int start;
        int kind;
        int hold;
        int len;
    } seg_t;

    typedef struct {
        int         cyc;
        logic       ovr;
        logic [1:0] st;
    } out_t;

    seg_t segs[$];
    int   exp_ovr_q[$];
    int   exp_next_q[$];
    out_t exp_out_q[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- stimulus plan ----------------
    int plan_start = 3;

    task automatic add_seg(input int kind, input int hold, input int gap);
        seg_t s;
        s.start = plan_start;
        s.kind  = kind;
        s.hold  = hold;
        s.len   = ((kind == K_TOG_OVR || kind == K_TOG_NEXT) ? 30 : hold) + gap;
        segs.push_back(s);
        plan_start += s.len;
    endtask

    // ---------------- reference model ----------------
    // Colour is an index into red -> green -> yellow; idle time is counted in whole tick edges.
    bit         m_manual = 1'b0;
    int         m_col = 0;
    int         m_act = 0;
    logic [1:0] colour_code [3] = '{2'b00, 2'b10, 2'b01};

    function automatic int timeout_edge(input int a);
        return (a / CLK_HZ + 1) * CLK_HZ + (TO - 1) * CLK_HZ + 1;
    endfunction

    task automatic push_out(input int c);
        out_t o;
        o.cyc = c;
        o.ovr = m_manual;
        o.st  = m_manual ? colour_code[m_col] : 2'b00;
        exp_out_q.push_back(o);
    endtask

    task automatic resolve(input int e);
        int m;
        if (m_manual) begin
            m = timeout_edge(m_act);
            if (m < e) begin
                m_manual = 1'b0;
                m_col    = 0;
                push_out(m);
            end
        end
    endtask

    task automatic build_model();
        int p;
        int e;
        foreach (segs[i]) begin
            if (segs[i].kind <= K_BOTH) begin
                p = segs[i].start + DB + 3;
                e = p + 1;
                resolve(e);
                if (segs[i].kind != K_NEXT) exp_ovr_q.push_back(p);
                if (segs[i].kind != K_OVR)  exp_next_q.push_back(p);
                if (segs[i].kind == K_NEXT) begin
                    if (m_manual) begin
                        m_col = (m_col + 1) % 3;
                        m_act = e;
                        push_out(e);
                    end
                end else begin
                    m_manual = !m_manual;
                    m_col    = 0;
                    m_act    = e;
                    push_out(e);
                end
            end
        end
        resolve(1 << 30);
    endtask

    // ---------------- monitor ----------------
    bit         mon_en = 1'b0;
    logic       prev_ovr = 1'b0;
    logic [1:0] prev_st = 2'b00;
    int         exp_c;
    out_t       exp_o;

    always @(negedge clk) begin
        if (mon_en) begin
            if (override_pulse) begin
                if (exp_ovr_q.size() == 0) begin
                    check(1'b0, "unexpected override_pulse", cyc, -1);
                end else begin
                    exp_c = exp_ovr_q.pop_front();
                    check(exp_c == cyc, "override_pulse cycle", cyc, exp_c);
                end
            end
            if (next_pulse) begin
                if (exp_next_q.size() == 0) begin
                    check(1'b0, "unexpected next_pulse", cyc, -1);
                end else begin
                    exp_c = exp_next_q.pop_front();
                    check(exp_c == cyc, "next_pulse cycle", cyc, exp_c);
                end
            end
            if (manual_override !== prev_ovr || manual_state !== prev_st) begin
                if (exp_out_q.size() == 0) begin
                    check(1'b0, "unexpected output change ovr/state", {29'd0, manual_override, manual_state}, -1);
                end else begin
                    exp_o = exp_out_q.pop_front();
                    check(exp_o.cyc == cyc && exp_o.ovr === manual_override && exp_o.st === manual_state,
                          "output change cycle*8+ovr*4+state",
                          cyc * 8 + {29'd0, manual_override, manual_state},
                          exp_o.cyc * 8 + {29'd0, exp_o.ovr, exp_o.st});
                end
            end
            prev_ovr = manual_override;
            prev_st  = manual_state;
        end
    end

    // ---------------- driver ----------------
    int si;
    int k;
    int kind;

    initial begin
        // Directed prologue: long hold, three nexts, glitches, timeout with restart, simultaneous presses.
        add_seg(K_OVR, 20, 12);
        add_seg(K_NEXT, 6, 10);
        add_seg(K_NEXT, 6, 10);
        add_seg(K_NEXT, 6, 10);
        add_seg(K_TOG_OVR, 0, 10);
        add_seg(K_GL_OVR, 3, 10);
        add_seg(K_OVR, 6, 14);
        add_seg(K_NEXT, 6, 55);
        add_seg(K_BOTH, 6, 12);
        add_seg(K_BOTH, 6, 12);
        add_seg(K_OVR, 4, 10);
        add_seg(K_GL_NEXT, 3, 10);
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 6);
            add_seg(kind, (kind <= K_BOTH) ? $urandom_range(4, 14) : 3, $urandom_range(10, 45));
        end
        build_model();

        repeat (3) @(posedge clk);
        #1;
        check(manual_override == 1'b0, "reset manual_override", manual_override, 0);
        check(manual_state == 2'b00, "reset manual_state", manual_state, 0);
        check(override_pulse == 1'b0, "reset override_pulse", override_pulse, 0);
        check(next_pulse == 1'b0, "reset next_pulse", next_pulse, 0);

        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        si     = 0;
        while (cyc < plan_start + 60) begin
            @(negedge clk);
            while (si < segs.size() && cyc >= segs[si].start + segs[si].len) si++;
            btn_override = 1'b0;
            btn_next     = 1'b0;
            if (si < segs.size() && cyc >= segs[si].start) begin
                k = cyc - segs[si].start;
                case (segs[si].kind)
                    K_OVR, K_GL_OVR: btn_override = (k < segs[si].hold);
                    K_NEXT, K_GL_NEXT: btn_next = (k < segs[si].hold);
                    K_BOTH: begin
                        btn_override = (k < segs[si].hold);
                        btn_next     = (k < segs[si].hold);
                    end
                    K_TOG_OVR:  btn_override = (k < 30) && ((k / 2) % 2 == 0);
                    K_TOG_NEXT: btn_next     = (k < 30) && ((k / 2) % 2 == 0);
                    default: ;
                endcase
            end
        end
        mon_en = 1'b0;
        check(exp_ovr_q.size() == 0, "missing override_pulses", exp_ovr_q.size(), 0);
        check(exp_next_q.size() == 0, "missing next_pulses", exp_next_q.size(), 0);
        check(exp_out_q.size() == 0, "missing output changes", exp_out_q.size(), 0);

        // Asynchronous reset while in MANUAL/green with a next press mid-debounce.
        btn_override = 1'b1;
        repeat (10) @(negedge clk);
        btn_override = 1'b0;
        check(manual_override == 1'b1, "enter manual before reset", manual_override, 1);
        repeat (10) @(negedge clk);
        btn_next = 1'b1;
        repeat (10) @(negedge clk);
        btn_next = 1'b0;
        check(manual_state == 2'b10, "green before reset", manual_state, 2);
        repeat (10) @(negedge clk);
        btn_next = 1'b1;
        repeat (4) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check(manual_override == 1'b0, "async reset manual_override", manual_override, 0);
        check(manual_state == 2'b00, "async reset manual_state", manual_state, 0);
        check(next_pulse == 1'b0, "async reset next_pulse", next_pulse, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i < 7) check(next_pulse == 1'b0, "held next early pulse after reset", next_pulse, 0);
            else       check(next_pulse == 1'b1 && cyc == 7, "held next pulse at cycle", cyc * 2 + next_pulse, 15);
        end
        btn_next = 1'b0;
        repeat (3) @(negedge clk);
        check(manual_override == 1'b0, "next ignored in auto", manual_override, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
